// File: rtl/uart_tx_feeder.sv
// Byte FIFO plus a two-state sequencer that feeds the UART transmitter one frame at a time.
// A watchdog abandons a frame if the transmitter never reports completion.
module uart_tx_feeder #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int DEPTH        = 16,
  parameter int TIMEOUT_CLKS = 12 * CLKS_PER_BIT
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [7:0]                 wr_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       tx_dv,
  output logic [7:0]                 tx_byte,
  input  logic                       tx_done,
  output logic                       busy,
  output logic                       tx_timeout
);

  localparam int AW  = $clog2(DEPTH);
  localparam int WDW = $clog2(TIMEOUT_CLKS + 1);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t          state_q, state_d;
  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic [WDW-1:0]  wdog_q, wdog_d;
  logic            tx_dv_q, overflow_q, tx_timeout_q;
  logic [7:0]      tx_byte_q;

  logic full_w, push, pop, wd_expire;

  // All decisions use pre-edge state, so nothing combinational reaches the outputs.
  assign full_w    = (count_q == (AW+1)'(DEPTH));
  assign push      = wr_en && !full_w;
  assign pop       = (state_q == S_IDLE) && (count_q != '0);
  assign wd_expire = (state_q == S_WAIT) && !tx_done && (wdog_q == WDW'(TIMEOUT_CLKS - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (pop) state_d = S_WAIT;
      S_WAIT:  if (tx_done || wd_expire) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == S_WAIT);
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
    wdog_d = wdog_q;
    if (pop) begin
      wdog_d = '0;
    end else if (state_q == S_WAIT) begin
      wdog_d = wdog_q + WDW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      mem[wr_ptr_q] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      wdog_q       <= '0;
      tx_dv_q      <= 1'b0;
      tx_byte_q    <= 8'h00;
      overflow_q   <= 1'b0;
      tx_timeout_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      wdog_q       <= wdog_d;
      tx_dv_q      <= pop;
      overflow_q   <= wr_en && full_w;
      tx_timeout_q <= wd_expire;
      if (pop) begin
        tx_byte_q <= mem[rd_ptr_q];
      end
    end
  end

  assign full       = full_w;
  assign empty      = (count_q == '0);
  assign count      = count_q;
  assign overflow   = overflow_q;
  assign tx_dv      = tx_dv_q;
  assign tx_byte    = tx_byte_q;
  assign tx_timeout = tx_timeout_q;

endmodule

// File: doc/uart_tx_feeder.md
# uart_tx_feeder

Byte buffer and transmit sequencer sitting directly upstream of the UART transmitter. It accepts bytes from on-chip producers, such as the receive path for echo or a command responder, into a 16-entry FIFO. It drains the FIFO one byte at a time into the UART_TX data-valid/byte/done handshake, never issuing a new byte before the previous frame completes. A watchdog recovers the sequencer if the transmitter never reports completion.

## Interface
- CLKS_PER_BIT, 5208, UART bit period in clocks (50 MHz / 9600 baud); sets the watchdog limit.
- DEPTH, 16, FIFO entries; power of two, minimum 2.
- TIMEOUT_CLKS, 12*CLKS_PER_BIT, clocks allowed in WAIT before abort.
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- wr_en  in  1  push wr_data this cycle.
- wr_data  in  8  byte to queue.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- count  out  log2(DEPTH)+1  bytes currently queued.
- overflow  out  1  one-cycle pulse: a write was dropped.
- tx_dv  out  1  one-cycle pulse to the UART_TX data-valid input.
- tx_byte  out  8  byte for UART_TX; stable from tx_dv until the next load.
- tx_done  in  1  one-cycle pulse from UART_TX at end of frame.
- busy  out  1  high in WAIT (frame in flight).
- tx_timeout  out  1  one-cycle pulse: watchdog aborted a frame.

## Operation
- Reset (rst_n low at an edge) sets rd_ptr = wr_ptr = 0, count = 0, state = IDLE, and clears the watchdog. Outputs: tx_dv 0, tx_byte 8'h00, overflow 0, tx_timeout 0, busy 0, empty 1, full 0. Memory contents are not reset.
- Reset mid-frame abandons the frame and discards all queued bytes. A tx_done arriving afterwards is ignored.
- FIFO: circular buffer; pointers are log2(DEPTH) bits and wrap from DEPTH-1 to 0.
- A write is accepted when wr_en=1 and full=0, where full is evaluated on the pre-edge count. It stores mem[wr_ptr] and increments wr_ptr.
- A write with full=1 is dropped and overflow pulses, even if a pop occurs on the same edge.
- Count update on a simultaneous accepted write and pop: count unchanged, both pointers advance.
- FSM has two states.
  - IDLE: if count != 0, then tx_byte <= mem[rd_ptr], tx_dv <= 1, rd_ptr++, count--, watchdog <= 0, state <= WAIT. Otherwise remain in IDLE.
  - WAIT: tx_dv <= 0; busy = 1; watchdog increments each cycle.
    - If tx_done = 1, go to IDLE.
    - Else if watchdog == TIMEOUT_CLKS-1, pulse tx_timeout and go to IDLE. The byte is lost, not retried.
- tx_done sampled while in IDLE is ignored.
- Pop with a simultaneous write on an empty FIFO is impossible: IDLE requires pre-edge count != 0, so no write-through bypass exists.

## Timing
- Write accepted at edge N, FIFO previously empty, FSM in IDLE: count=1 after N, tx_dv high after edge N+1 for exactly one cycle, count=0 after N+1.
- tx_done at edge M: state returns to IDLE at M, and the next tx_dv is high after edge M+1 at the earliest. This gives a minimum one-cycle gap, which UART_TX needs for its cleanup state.
- Back-to-back frames: tx_dv spacing = frame length + 2 clocks.
- overflow and tx_timeout are registered, high for the cycle after the triggering edge.
- full, empty, count, and busy reflect post-edge state with no combinational path from inputs.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with wr_en=1 -> count=0, empty=1, tx_dv=0, tx_byte=8'h00; release -> no tx_dv.
- Single byte: write 8'hA5 at edge N -> tx_dv one cycle after N+1 with tx_byte=8'hA5; model tx_done 10*CLKS_PER_BIT later -> busy falls, empty=1.
- Ordering and wrap: write 20 bytes 8'h00..8'h13 while tx_done is withheld.
  - 8'h00 is popped immediately, so 16 more fill the FIFO and the last three (8'h11..8'h13) each pulse overflow.
  - Then tx_done per frame -> 17 bytes emitted in order 8'h00..8'h10, with pointers wrapping.
- Simultaneous push/pop: FIFO holding 3 bytes in IDLE, write on the load edge -> count stays 3, order preserved.
- Watchdog: load 8'h3C, never assert tx_done -> tx_timeout pulses TIMEOUT_CLKS cycles after entering WAIT; the next queued byte loads one cycle later.
- Reset mid-frame: 5 bytes queued, one in flight, rst_n=0 for 1 cycle -> count=0; a late tx_done is ignored and no further tx_dv occurs.
